paddsb_acc_seq: RTL and testbench



---
 rtl/paddsb_acc_seq.sv | 141 ++++++++++++++
 tb/tb_paddsb_acc_seq.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/paddsb_acc_seq.sv
// ---------------------------------------------------------------------------
// paddsb_acc_seq
//
// Purpose:
//   Multi-cycle sequencer that drives a shared, purely combinational 16-bit
//   4-lane saturating nibble adder to accumulate a stream of operand words
//   into one packed result. The sequencer owns the accumulator, the
//   remaining-beat count, the valid/ready handshake and the sticky per-lane
//   saturation flags. The adder result is taken as-is; saturation flags are
//   derived here from the adder operands so the adder stays flag-free.
//
// Ports:
//   clk        in   clock, all state on rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   begin an operation (sampled only in IDLE)
//   len        in   number of operand beats to accumulate (0 allowed)
//   init       in   initial accumulator value loaded on start
//   abort      in   synchronous cancel of an in-progress operation
//   in_data    in   operand word
//   in_valid   in   operand word valid
//   in_ready   out  operand accepted this cycle when in_valid is also high
//   add_a      out  adder operand A (accumulator)
//   add_b      out  adder operand B (operand word)
//   add_res    in   saturated packed sum from the shared adder
//   acc_out    out  accumulator / final result
//   sat_lanes  out  sticky per-nibble saturation flags, bit i = lane i
//   busy       out  operation in progress (RUN or DONE)
//   done       out  one-cycle completion pulse
// ---------------------------------------------------------------------------
module paddsb_acc_seq #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic [15:0]      init,
  input  logic             abort,
  input  logic [15:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [15:0]      add_a,
  output logic [15:0]      add_b,
  input  logic [15:0]      add_res,
  output logic [15:0]      acc_out,
  output logic [3:0]       sat_lanes,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      acc_q, acc_d;
  logic [3:0]       satLanes_q, satLanes_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [3:0]       laneOvf;

  // The adder is shared with other users, so its operands are always
  // presented regardless of the sequencer state.
  assign add_a = acc_q;
  assign add_b = in_data;

  // Signed overflow per nibble: operands share a sign and the wrapped
  // 4-bit sum flips it. Computed from the operands, not from add_res,
  // because the saturated result no longer carries the wrap information.
  always_comb begin
    laneOvf = '0;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] wrapSum;
      wrapSum    = acc_q[4*i +: 4] + in_data[4*i +: 4];
      laneOvf[i] = (acc_q[4*i+3] == in_data[4*i+3]) &&
                   (wrapSum[3] != acc_q[4*i+3]);
    end
  end

  // abort suppresses the handshake in the same cycle so a beat presented
  // alongside abort is never consumed by either side.
  assign in_ready  = (state_q == RUN) && !abort;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign acc_out   = acc_q;
  assign sat_lanes = satLanes_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    satLanes_d  = satLanes_q;
    remaining_d = remaining_q;
    case (state_q)
      IDLE: begin
        // start takes priority over a concurrent abort here since abort
        // only has meaning while running.
        if (start) begin
          acc_d       = init;
          satLanes_d  = '0;
          remaining_d = len;
          state_d     = (len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (abort) begin
          // Partial accumulator and flags are intentionally kept.
          state_d = IDLE;
        end else if (in_valid) begin
          acc_d       = add_res;
          satLanes_d  = satLanes_q | laneOvf;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == CNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      satLanes_q  <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      satLanes_q  <= satLanes_d;
      remaining_q <= remaining_d;
    end
  end

endmodule

// File: tb/tb_paddsb_acc_seq.sv
// ---------------------------------------------------------------------------
// tb_paddsb_acc_seq
//
// Purpose:
//   Directed self-checking bench for paddsb_acc_seq. Provides a behavioural
//   model of the shared saturating nibble adder on add_a/add_b -> add_res
//   and walks through a linear sequence of directed operations with
//   hand-computed expected results.
// ---------------------------------------------------------------------------
module tb_paddsb_acc_seq;

  logic        clk;
  logic        rstN;
  logic        start;
  logic [3:0]  lenIn;
  logic [15:0] initVal;
  logic        abortIn;
  logic [15:0] inData;
  logic        inValid;
  logic        inReady;
  logic [15:0] addA;
  logic [15:0] addB;
  logic [15:0] addRes;
  logic [15:0] accOut;
  logic [3:0]  satLanes;
  logic        busy;
  logic        done;

  int checkCount = 0;
  int errorCount = 0;

  paddsb_acc_seq #(.CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rstN),
    .start     (start),
    .len       (lenIn),
    .init      (initVal),
    .abort     (abortIn),
    .in_data   (inData),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .add_a     (addA),
    .add_b     (addB),
    .add_res   (addRes),
    .acc_out   (accOut),
    .sat_lanes (satLanes),
    .busy      (busy),
    .done      (done)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference saturating nibble adder standing in for the shared datapath.
  function automatic logic [15:0] satAdd(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic signed [4:0] s;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      s = $signed({a[4*i+3], a[4*i +: 4]}) + $signed({b[4*i+3], b[4*i +: 4]});
      if (s > 5'sd7)       r[4*i +: 4] = 4'h7;
      else if (s < -5'sd8) r[4*i +: 4] = 4'h8;
      else                 r[4*i +: 4] = s[3:0];
    end
    return r;
  endfunction

  // The adder model is combinational, matching the real shared adder.
  always_comb begin
    addRes = satAdd(addA, addB);
  end

  // Advance to just after the next rising edge so outputs are settled.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Drive every sequencer input in one go with blocking assignments.
  task automatic applyStimulus(input logic st, input logic [3:0] ln, input logic [15:0] iv,
                               input logic ab, input logic [15:0] dat, input logic vld);
    start   = st;
    lenIn   = ln;
    initVal = iv;
    abortIn = ab;
    inData  = dat;
    inValid = vld;
  endtask

  // Single comparison point: counts the check and reports any difference.
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      errorCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Linear directed sequence covering reset, accumulation, saturation,
  // zero-length operations, bubbles, ignored start, abort and async reset.
  initial begin
    rstN = 1'b0;
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    #2;
    checkOutput("reset_acc",   accOut, 16'h0000);
    checkOutput("reset_sat",   {12'h0, satLanes}, 16'h0000);
    checkOutput("reset_busy",  {15'h0, busy}, 16'h0000);
    checkOutput("reset_done",  {15'h0, done}, 16'h0000);
    checkOutput("reset_ready", {15'h0, inReady}, 16'h0000);
    #20;
    rstN = 1'b1;
    stepCycle();

    // Plain two-beat accumulation without saturation.
    $display("[TB] two-beat accumulate");
    applyStimulus(1'b1, 4'd2, 16'h0000, 1'b0, 16'h0000, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 4'd2, 16'h0000, 1'b0, 16'h1234, 1'b1);
    #1;
    checkOutput("t1_ready_run", {15'h0, inReady}, 16'h0001);
    checkOutput("t1_busy_run",  {15'h0, busy}, 16'h0001);
    stepCycle();
    checkOutput("t1_acc_beat1", accOut, 16'h1234);
    inData = 16'h1111;
    stepCycle();
    inValid = 1'b0;
    checkOutput("t1_done",     {15'h0, done}, 16'h0001);
    checkOutput("t1_busy_done", {15'h0, busy}, 16'h0001);
    checkOutput("t1_ready_done", {15'h0, inReady}, 16'h0000);
    checkOutput("t1_acc",      accOut, 16'h2345);
    checkOutput("t1_sat",      {12'h0, satLanes}, 16'h0000);
    stepCycle();
    checkOutput("t1_done_low", {15'h0, done}, 16'h0000);
    checkOutput("t1_idle",     {15'h0, busy}, 16'h0000);
    checkOutput("t1_acc_hold", accOut, 16'h2345);

    // Positive saturation in lane 3, then negative saturation in lane 0
    // with the sticky flags cleared by the second start.
    $display("[TB] saturation lanes");
    applyStimulus(1'b1, 4'd1, 16'h7000, 1'b0, 16'h0000, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0, 16'h1000, 1'b1);
    stepCycle();
    inValid = 1'b0;
    checkOutput("t2_done_pos", {15'h0, done}, 16'h0001);
    checkOutput("t2_acc_pos",  accOut, 16'h7000);
    checkOutput("t2_sat_pos",  {12'h0, satLanes}, 16'h0008);
    stepCycle();
    applyStimulus(1'b1, 4'd1, 16'h0008, 1'b0, 16'h0000, 1'b0);
    stepCycle();
    checkOutput("t2_sat_clear", {12'h0, satLanes}, 16'h0000);
    checkOutput("t2_acc_init",  accOut, 16'h0008);
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0, 16'h000F, 1'b1);
    stepCycle();
    inValid = 1'b0;
    checkOutput("t2_done_neg", {15'h0, done}, 16'h0001);
    checkOutput("t2_acc_neg",  accOut, 16'h0008);
    checkOutput("t2_sat_neg",  {12'h0, satLanes}, 16'h0001);
    stepCycle();

    // Zero-length operation: straight to DONE, never ready.
    $display("[TB] zero-length operation");
    applyStimulus(1'b1, 4'd0, 16'hABCD, 1'b0, 16'h5555, 1'b1);
    #1;
    checkOutput("t3_ready_idle", {15'h0, inReady}, 16'h0000);
    stepCycle();
    start = 1'b0;
    checkOutput("t3_done",  {15'h0, done}, 16'h0001);
    checkOutput("t3_ready", {15'h0, inReady}, 16'h0000);
    checkOutput("t3_acc",   accOut, 16'hABCD);
    stepCycle();
    inValid = 1'b0;
    checkOutput("t3_done_low", {15'h0, done}, 16'h0000);
    checkOutput("t3_acc_hold", accOut, 16'hABCD);

    // Bubbles in the stream plus start pulses while running.
    $display("[TB] bubbles and ignored start");
    applyStimulus(1'b1, 4'd3, 16'h0000, 1'b0, 16'h0001, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 4'd3, 16'h0000, 1'b0, 16'h0001, 1'b1);
    stepCycle();
    checkOutput("t4_acc_v1", accOut, 16'h0001);
    applyStimulus(1'b1, 4'd5, 16'hFFFF, 1'b0, 16'h0001, 1'b0);
    stepCycle();
    checkOutput("t4_acc_b1", accOut, 16'h0001);
    stepCycle();
    checkOutput("t4_acc_b2", accOut, 16'h0001);
    checkOutput("t4_busy_b2", {15'h0, busy}, 16'h0001);
    applyStimulus(1'b0, 4'd3, 16'h0000, 1'b0, 16'h0001, 1'b1);
    stepCycle();
    checkOutput("t4_acc_v2", accOut, 16'h0002);
    checkOutput("t4_done_early", {15'h0, done}, 16'h0000);
    inValid = 1'b0;
    stepCycle();
    checkOutput("t4_acc_b3", accOut, 16'h0002);
    inValid = 1'b1;
    stepCycle();
    inValid = 1'b0;
    checkOutput("t4_done", {15'h0, done}, 16'h0001);
    checkOutput("t4_acc",  accOut, 16'h0003);
    stepCycle();
    checkOutput("t4_idle", {15'h0, busy}, 16'h0000);

    // Abort after two beats with a beat offered in the abort cycle.
    $display("[TB] abort mid-run");
    applyStimulus(1'b1, 4'd4, 16'h0000, 1'b0, 16'h0010, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 4'd4, 16'h0000, 1'b0, 16'h0010, 1'b1);
    stepCycle();
    stepCycle();
    checkOutput("t5_acc_two", accOut, 16'h0020);
    abortIn = 1'b1;
    #1;
    checkOutput("t5_ready_abort", {15'h0, inReady}, 16'h0000);
    stepCycle();
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    checkOutput("t5_busy", {15'h0, busy}, 16'h0000);
    checkOutput("t5_done", {15'h0, done}, 16'h0000);
    checkOutput("t5_acc",  accOut, 16'h0020);
    stepCycle();
    checkOutput("t5_done_later", {15'h0, done}, 16'h0000);

    // Asynchronous reset between edges while running.
    $display("[TB] async reset mid-run");
    applyStimulus(1'b1, 4'd4, 16'h1111, 1'b0, 16'h0001, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 4'd4, 16'h1111, 1'b0, 16'h0001, 1'b1);
    stepCycle();
    checkOutput("t6_acc_pre", accOut, 16'h1112);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("t6_acc_rst",   accOut, 16'h0000);
    checkOutput("t6_busy_rst",  {15'h0, busy}, 16'h0000);
    checkOutput("t6_ready_rst", {15'h0, inReady}, 16'h0000);
    checkOutput("t6_sat_rst",   {12'h0, satLanes}, 16'h0000);
    checkOutput("t6_done_rst",  {15'h0, done}, 16'h0000);
    #2;
    rstN = 1'b1;
    stepCycle();
    stepCycle();
    checkOutput("t6_idle_busy", {15'h0, busy}, 16'h0000);
    checkOutput("t6_idle_acc",  accOut, 16'h0000);
    applyStimulus(1'b1, 4'd1, 16'h0005, 1'b0, 16'h0002, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0, 16'h0002, 1'b1);
    stepCycle();
    inValid = 1'b0;
    checkOutput("t6_restart_done", {15'h0, done}, 16'h0001);
    checkOutput("t6_restart_acc",  accOut, 16'h0007);
    stepCycle();

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
